// File: rtl/obf_key_pkg.sv
// Shared types and default sizing for the obfuscation key loader.
package obf_key_pkg;

  localparam int unsigned KeyWDefault    = 2;
  localparam int unsigned TimeoutDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StParity,
    StCommit,
    StError
  } key_state_e;

endpackage

// File: rtl/obf_key_timer.sv
// Idle-cycle watchdog: clear has priority over increment. The expire flag fires on the
// increment that would bring the count to TIMEOUT.
module obf_key_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + CntW'(1);
      expire  = (count_q == CntW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader for a logic-locked core: shifts in KEY_W bits plus an even-parity
// bit, then commits the key to D, or clears D and flags KEY_ERR on parity error/timeout.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int unsigned KEY_W   = KeyWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             LOAD_START,
  input  logic             KEY_IN_VALID,
  input  logic             KEY_IN_BIT,
  output logic             KEY_IN_READY,
  output logic [KEY_W-1:0] D,
  output logic             KEY_VALID,
  output logic             KEY_ERR,
  output logic             BUSY
);

  localparam int unsigned CntW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  key_state_e      state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] d_q, d_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;

  logic in_load;
  logic accept;
  logic restart;
  logic timer_clear;
  logic timer_incr;
  logic timer_expire;

  obf_key_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (CK),
    .rst_n (RST_N),
    .clear (timer_clear),
    .incr  (timer_incr),
    .expire(timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    d_d         = d_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;

    in_load      = (state_q == StShift) || (state_q == StParity);
    KEY_IN_READY = in_load;
    BUSY         = in_load || (state_q == StCommit);
    accept       = in_load && KEY_IN_VALID;
    restart      = LOAD_START && (state_q != StCommit);
    timer_clear  = restart || accept || !in_load;
    timer_incr   = in_load && !accept;

    if (restart) begin
      // Restart wins over a coincident bit or timeout; the bit is dropped.
      state_d     = StShift;
      shadow_d    = '0;
      bit_cnt_d   = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StShift: begin
          if (accept) begin
            shadow_d[bit_cnt_q] = KEY_IN_BIT;
            bit_cnt_d           = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == CntW'(KEY_W - 1)) begin
              state_d = StParity;
            end
          end else if (timer_expire) begin
            state_d     = StError;
            d_d         = '0;
            key_valid_d = 1'b0;
            key_err_d   = 1'b1;
          end
        end
        StParity: begin
          if (accept && (KEY_IN_BIT == ^shadow_q)) begin
            state_d = StCommit;
          end else if (accept || timer_expire) begin
            state_d     = StError;
            d_d         = '0;
            key_valid_d = 1'b0;
            key_err_d   = 1'b1;
          end
        end
        StCommit: begin
          state_d     = StIdle;
          d_d         = shadow_q;
          key_valid_d = 1'b1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      d_q         <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      d_q         <= d_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  assign D         = d_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_ERR   = key_err_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// Bench for obf_key_loader: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level model of the key load protocol.
module tb_obf_key_loader;

  localparam int unsigned KEY_W   = 2;
  localparam int unsigned TIMEOUT = 16;

  logic             CK = 1'b0;
  logic             RST_N = 1'b0;
  logic             LOAD_START = 1'b0;
  logic             KEY_IN_VALID = 1'b0;
  logic             KEY_IN_BIT = 1'b0;
  logic             KEY_IN_READY;
  logic [KEY_W-1:0] D;
  logic             KEY_VALID;
  logic             KEY_ERR;
  logic             BUSY;

  obf_key_loader #(
    .KEY_W  (KEY_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CK          (CK),
    .RST_N       (RST_N),
    .LOAD_START  (LOAD_START),
    .KEY_IN_VALID(KEY_IN_VALID),
    .KEY_IN_BIT  (KEY_IN_BIT),
    .KEY_IN_READY(KEY_IN_READY),
    .D           (D),
    .KEY_VALID   (KEY_VALID),
    .KEY_ERR     (KEY_ERR),
    .BUSY        (BUSY)
  );

  always #5 CK = ~CK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model: a load collects bits into a queue; the (KEY_W+1)-th bit closes the transaction.
  bit             m_loading;
  bit             m_commit;
  bit [KEY_W-1:0] m_key;
  bit [KEY_W-1:0] m_d;
  bit             m_valid;
  bit             m_err;
  bit             m_bits[$];
  int             m_idle;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".ready"}, 32'(KEY_IN_READY), 32'(m_loading));
    check_eq({tag, ".busy"},  32'(BUSY),         32'(m_loading | m_commit));
    check_eq({tag, ".d"},     32'(D),            32'(m_d));
    check_eq({tag, ".valid"}, 32'(KEY_VALID),    32'(m_valid));
    check_eq({tag, ".err"},   32'(KEY_ERR),      32'(m_err));
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_commit  = 1'b0;
    m_key     = '0;
    m_d       = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_idle    = 0;
    m_bits.delete();
  endtask

  task automatic model_fail();
    m_loading = 1'b0;
    m_d       = '0;
    m_valid   = 1'b0;
    m_err     = 1'b1;
  endtask

  function automatic bit key_parity();
    bit p = 1'b0;
    foreach (m_bits[i]) p ^= m_bits[i];
    return p;
  endfunction

  task automatic model_step(input bit ls, input bit v, input bit b);
    if (m_commit) begin
      m_commit = 1'b0;
      m_d      = m_key;
      m_valid  = 1'b1;
    end else if (ls) begin
      m_loading = 1'b1;
      m_bits.delete();
      m_idle  = 0;
      m_err   = 1'b0;
      m_valid = 1'b0;
    end else if (m_loading) begin
      if (v) begin
        m_bits.push_back(b);
        m_idle = 0;
        if (m_bits.size() == KEY_W + 1) begin
          if (key_parity() == 1'b0) begin
            m_loading = 1'b0;
            m_commit  = 1'b1;
            for (int i = 0; i < KEY_W; i++) m_key[i] = m_bits[i];
          end else begin
            model_fail();
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) model_fail();
      end
    end
  endtask

  task automatic step(input bit ls, input bit v, input bit b);
    LOAD_START   = ls;
    KEY_IN_VALID = v;
    KEY_IN_BIT   = b;
    #1;
    check_outputs("cyc");
    model_step(ls, v, b);
    @(posedge CK);
    #1;
  endtask

  task automatic reset_now();
    RST_N = 1'b0;
    #1;
    check_eq("rst_async.d",     32'(D),            32'd0);
    check_eq("rst_async.valid", 32'(KEY_VALID),    32'd0);
    check_eq("rst_async.err",   32'(KEY_ERR),      32'd0);
    check_eq("rst_async.busy",  32'(BUSY),         32'd0);
    check_eq("rst_async.ready", 32'(KEY_IN_READY), 32'd0);
    model_reset();
    @(posedge CK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge CK);
    #1;
    check_outputs("reset");
    RST_N = 1'b1;

    // Good load 1,0 + parity 1 -> D=01 two cycles after parity bit.
    step(1, 0, 0); step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    check_eq("lat.n1_valid", 32'(KEY_VALID), 32'd0);
    step(0, 0, 0);
    check_eq("good01.d", 32'(D), 32'h1);
    check_eq("good01.valid", 32'(KEY_VALID), 32'd1);
    check_eq("good01.err", 32'(KEY_ERR), 32'd0);

    // Restart coincident with a bit discards that bit.
    step(1, 0, 0); step(0, 1, 1); step(1, 1, 1);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 1); step(0, 0, 0);
    check_eq("restart.d", 32'(D), 32'h2);
    check_eq("restart.valid", 32'(KEY_VALID), 32'd1);

    // LOAD_START in IDLE clears KEY_VALID but keeps D; LOAD_START in COMMIT is ignored.
    step(1, 0, 0);
    check_eq("ls_idle.d", 32'(D), 32'h2);
    check_eq("ls_idle.valid", 32'(KEY_VALID), 32'd0);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 0); step(1, 0, 0);
    check_eq("ls_commit.d", 32'(D), 32'h3);
    check_eq("ls_commit.valid", 32'(KEY_VALID), 32'd1);
    check_eq("ls_commit.busy", 32'(BUSY), 32'd0);

    // Bad parity after a good load of 11.
    step(1, 0, 0); step(0, 1, 1); step(0, 1, 0); step(0, 1, 0);
    check_eq("badpar.d", 32'(D), 32'h0);
    check_eq("badpar.valid", 32'(KEY_VALID), 32'd0);
    check_eq("badpar.err", 32'(KEY_ERR), 32'd1);

    // KEY_IN_VALID toggling in ERROR, then in IDLE.
    for (int i = 0; i < 6; i++) step(0, i[0], 1);
    check_eq("err_toggle.err", 32'(KEY_ERR), 32'd1);
    check_eq("err_toggle.d", 32'(D), 32'h0);
    step(1, 0, 0); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1); step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, i[0], 0);
    check_eq("idle_toggle.d", 32'(D), 32'h2);
    check_eq("idle_toggle.valid", 32'(KEY_VALID), 32'd1);

    // Timeout: one bit then silence; still busy after TIMEOUT-1 idle cycles.
    step(1, 0, 0); step(0, 1, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0);
    check_eq("tmo.busy_edge", 32'(BUSY), 32'd1);
    step(0, 0, 0);
    check_eq("tmo.err", 32'(KEY_ERR), 32'd1);
    check_eq("tmo.d", 32'(D), 32'h0);
    check_eq("tmo.busy", 32'(BUSY), 32'd0);

    // Reset while waiting for parity.
    step(1, 0, 0); step(0, 1, 1); step(0, 1, 1);
    reset_now();
    step(0, 1, 0); step(0, 0, 0);
    check_eq("rst_mid.valid", 32'(KEY_VALID), 32'd0);

    // Randomized traffic with alternating busy and sparse bit streams.
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned vprob = (blk % 3 == 2) ? 5 : 60;
      for (int i = 0; i < 200; i++) begin
        bit ls, v, b;
        if ($urandom_range(0, 399) == 0) reset_now();
        ls = ($urandom_range(0, 29) == 0);
        v  = ($urandom_range(0, 99) < vprob);
        b  = 1'($urandom_range(0, 1));
        if (m_loading && m_bits.size() == KEY_W && $urandom_range(0, 3) != 0) b = key_parity();
        step(ls, v, b);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obf_key_loader.md
OBF_KEY_LOADER -- requirements
Module: obf_key_loader

Interface
REQ-001 Parameter KEY_W, default 2, number of key bits driven to the locked core.
REQ-002 Parameter TIMEOUT, default 16, idle cycles allowed between accepted bits before abort.
REQ-003 Clocking: one clock, CK; reset RST_N is asynchronous and active-low.
REQ-004 CK  input  1  sole clock, rising-edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 LOAD_START  input  1  single-cycle request to begin a key load.
REQ-007 KEY_IN_VALID  input  1  serial key bit present on KEY_IN_BIT.
REQ-008 KEY_IN_BIT  input  1  serial key/parity data, LSB first.
REQ-009 KEY_IN_READY  output  1  loader accepts a bit this cycle.
REQ-010 D  output  KEY_W  committed key to the locked core; D[0] drives D_0, D[1] drives D_1.
REQ-011 KEY_VALID  output  1  D holds a parity-checked key.
REQ-012 KEY_ERR  output  1  last load failed (parity or timeout).
REQ-013 BUSY  output  1  a load is in progress.

Function
REQ-014 FSM states: IDLE, SHIFT, PARITY, COMMIT, ERROR.
REQ-015 A bit is accepted only on a cycle with KEY_IN_VALID=1 and KEY_IN_READY=1.
REQ-016 KEY_IN_READY=1 exactly in SHIFT and PARITY; BUSY=1 in SHIFT, PARITY and COMMIT.
REQ-017 IDLE or ERROR with LOAD_START=1 -> SHIFT next cycle; shadow register, bit counter and timeout counter cleared; KEY_ERR cleared; KEY_VALID cleared.
REQ-018 SHIFT: each accepted bit is written to shadow[count], count increments; the KEY_W-th accepted bit moves to PARITY.
REQ-019 PARITY: the accepted bit must equal the XOR of all shadow bits (even parity over key plus parity bit); match -> COMMIT, mismatch -> ERROR.
REQ-020 COMMIT lasts one cycle: D <= shadow, KEY_VALID <= 1 on exit, then IDLE; D changes only on this transition or on entry to ERROR.
REQ-021 ERROR entry: D <= 0, KEY_VALID <= 0, KEY_ERR <= 1; stays in ERROR until LOAD_START.
REQ-022 Timeout: in SHIFT/PARITY the counter increments on every cycle without an accepted bit and clears on acceptance; reaching TIMEOUT -> ERROR.
REQ-023 LOAD_START in SHIFT or PARITY restarts the load (same as REQ-017); LOAD_START coincident with an accepted bit gives restart priority and the bit is discarded.
REQ-024 LOAD_START in COMMIT is ignored; LOAD_START in IDLE while KEY_VALID=1 clears KEY_VALID but leaves D unchanged until the next COMMIT or ERROR.
REQ-025 KEY_IN_VALID outside SHIFT/PARITY is ignored, no state change.
REQ-026 Latency: last (parity) bit accepted in cycle n -> KEY_VALID=1 and new D visible in cycle n+2.

Reset
REQ-027 RST_N low asynchronously forces IDLE, D=0, KEY_VALID=0, KEY_ERR=0, BUSY=0, KEY_IN_READY=0, shadow and counters 0.
REQ-028 Reset mid-load discards the partial key; outputs remain at reset values until a full successful load.
REQ-029 Release of RST_N is synchronised to CK by the integrator; the block requires no cycles after release before accepting LOAD_START.

Structure
REQ-030 Package obf_key_pkg holds the FSM state enumeration and default KEY_W/TIMEOUT constants.
REQ-031 One sub-module, obf_key_timer, implements the clear/increment/expire timeout counter; all else is in obf_key_loader.
REQ-032 Outputs D, KEY_VALID, KEY_ERR are registered; no combinational path from inputs to D.

Verification
REQ-033 Reset, LOAD_START, bits 1,0 then parity 1 -> D=2'b01, KEY_VALID=1, KEY_ERR=0 two cycles after parity bit.
REQ-034 After a good load of 2'b11, load bits 1,0 with parity 0 -> ERROR, D=2'b00, KEY_VALID=0, KEY_ERR=1.
REQ-035 LOAD_START, one bit accepted, then KEY_IN_VALID=0 for 16 cycles -> ERROR, KEY_ERR=1, D=0.
REQ-036 LOAD_START, bit 1 accepted, LOAD_START with KEY_IN_VALID=1 same cycle, then 0,1,parity 1 -> D=2'b10; first bit discarded.
REQ-037 Assert RST_N low in PARITY after bits 1,1 -> outputs at reset values immediately; no KEY_VALID without a new complete load.
REQ-038 KEY_IN_VALID toggling in IDLE and ERROR -> KEY_IN_READY=0, no change to D or state.
